// File: rtl/mem_pkg.sv
// Shared definitions for the cache-controller memory path: default widths,
// arbiter state encoding and requester identifiers.
package mem_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int LINE_W_DEF = 64;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam logic OWNER_IC = 1'b0;
  localparam logic OWNER_DC = 1'b1;

endpackage

// File: rtl/ram_arbiter_rr_pick.sv
// Two-way round-robin grant: a lone request wins outright; on a tie the
// requester that was not served last wins.
module rr_pick
  import mem_pkg::*;
(
  input  logic req_ic_i,
  input  logic req_dc_i,
  input  logic last_i,
  output logic gnt_valid_o,
  output logic gnt_dc_o
);

  // Grant decision is purely combinational from the request pair and history.
  always_comb begin
    gnt_valid_o = req_ic_i | req_dc_i;
    gnt_dc_o    = req_dc_i & (~req_ic_i | (last_i == OWNER_IC));
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one RAM port between the icache and dcache miss paths. One access
// at a time: grant in IDLE, hold ram_en through ACCESS, pulse the owner's ack
// in RESP. A watchdog turns a never-completing access into an error response.
module ram_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int LINE_W  = LINE_W_DEF,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_ack,
  output logic [LINE_W-1:0] ic_data,
  input  logic              dc_req,
  input  logic              dc_we,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [LINE_W-1:0] dc_wdata,
  output logic              dc_ack,
  output logic [LINE_W-1:0] dc_data,
  output logic              err,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [LINE_W-1:0] ram_wdata,
  input  logic [LINE_W-1:0] ram_rdata,
  input  logic              ram_done,
  output logic              owner
);

  localparam int WDOG_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic                owner_q, owner_d;
  logic                last_q, last_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LINE_W-1:0]   wdata_q, wdata_d;
  logic [WDOG_W-1:0]   wdog_q, wdog_d;
  logic                err_flag_q, err_flag_d;
  logic [LINE_W-1:0]   ic_data_q, ic_data_d;
  logic [LINE_W-1:0]   dc_data_q, dc_data_d;
  logic [LINE_W-1:0]   line_d;

  logic gnt_valid;
  logic gnt_dc;

  rr_pick u_rr_pick (
    .req_ic_i    (ic_req),
    .req_dc_i    (dc_req),
    .last_i      (last_q),
    .gnt_valid_o (gnt_valid),
    .gnt_dc_o    (gnt_dc)
  );

  // State and datapath registers; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      owner_q    <= OWNER_IC;
      last_q     <= OWNER_DC;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wdog_q     <= '0;
      err_flag_q <= 1'b0;
      ic_data_q  <= '0;
      dc_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wdog_q     <= wdog_d;
      err_flag_q <= err_flag_d;
      ic_data_q  <= ic_data_d;
      dc_data_q  <= dc_data_d;
    end
  end

  // Next-state logic: grant in IDLE, complete or time out in ACCESS, then RESP.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wdog_d     = wdog_q;
    err_flag_d = err_flag_q;
    ic_data_d  = ic_data_q;
    dc_data_d  = dc_data_q;
    line_d     = '0;

    case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          owner_d    = gnt_dc;
          last_d     = gnt_dc;
          wdog_d     = '0;
          err_flag_d = 1'b0;
          state_d    = ST_ACCESS;
          if (gnt_dc) begin
            we_d    = dc_we;
            addr_d  = dc_addr;
            wdata_d = dc_wdata;
          end else begin
            we_d    = 1'b0;
            addr_d  = ic_addr;
            wdata_d = '0;
          end
        end
      end

      ST_ACCESS: begin
        // A completion in the final watchdog cycle still counts as success.
        if (ram_done || (wdog_q == WDOG_LAST)) begin
          if (ram_done && !we_q) begin
            line_d = ram_rdata;
          end
          err_flag_d = ~ram_done;
          state_d    = ST_RESP;
          if (owner_q == OWNER_DC) begin
            dc_data_d = line_d;
          end else begin
            ic_data_d = line_d;
          end
        end else begin
          wdog_d = wdog_q + WDOG_W'(1);
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs decode directly from registered state so they are glitch-free.
  always_comb begin
    ram_en    = (state_q == ST_ACCESS);
    ram_we    = (state_q == ST_ACCESS) & we_q;
    ram_addr  = addr_q;
    ram_wdata = wdata_q;
    ic_ack    = (state_q == ST_RESP) & (owner_q == OWNER_IC);
    dc_ack    = (state_q == ST_RESP) & (owner_q == OWNER_DC);
    err       = (state_q == ST_RESP) & err_flag_q;
    ic_data   = ic_data_q;
    dc_data   = dc_data_q;
    owner     = owner_q;
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: stimulus pushes expected transactions,
// a negedge monitor checks RAM-side issue and the ack/data/err response.
module tb_ram_arbiter;
  import mem_pkg::*;

  localparam int AW = 32;
  localparam int LW = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          ic_req, dc_req, dc_we;
  logic [AW-1:0] ic_addr, dc_addr;
  logic [LW-1:0] dc_wdata;
  logic          ic_ack, dc_ack, err;
  logic [LW-1:0] ic_data, dc_data;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [LW-1:0] ram_wdata;
  logic [LW-1:0] ram_rdata;
  logic          ram_done;
  logic          owner;

  ram_arbiter #(.ADDR_W(AW), .LINE_W(LW), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_ack(ic_ack), .ic_data(ic_data),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_ack(dc_ack), .dc_data(dc_data), .err(err),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_done(ram_done), .owner(owner)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          own;
    logic [AW-1:0] addr;
    logic          we;
    logic [LW-1:0] wdata;
    logic [LW-1:0] data;
    logic          err;
    int            en_cycles;
  } exp_t;

  exp_t sb_q[$];

  int checks    = 0;
  int failures  = 0;
  int ack_count = 0;
  int mon_en_cnt = 0;
  bit mon_first  = 1'b1;

  // RAM model controls
  int            done_at   = 0;   // ACCESS cycle on which ram_done rises, 0 = never
  int            acc_cnt   = 0;
  bit            stray     = 1'b0;
  logic [LW-1:0] rdata_val = '0;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic push(input logic o, input logic [AW-1:0] a, input logic w,
                      input logic [LW-1:0] wd, input logic [LW-1:0] d,
                      input logic e, input int n);
    exp_t x;
    x.own = o; x.addr = a; x.we = w; x.wdata = wd; x.data = d; x.err = e; x.en_cycles = n;
    sb_q.push_back(x);
  endtask

  task automatic wait_acks(input int target, input int budget);
    int n;
    n = 0;
    while (ack_count < target && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    checks++;
    if (ack_count < target) begin
      failures++;
      $display("FAIL ack_wait_timeout actual=%0d expected=%0d", ack_count, target);
    end
  endtask

  // RAM model: completes on a programmed ACCESS cycle, or strobes done while idle.
  always @(negedge clk) begin
    if (ram_en) begin
      acc_cnt++;
      ram_done = (acc_cnt == done_at);
    end else begin
      acc_cnt  = 0;
      ram_done = stray;
    end
    ram_rdata = rdata_val;
  end

  // Monitor: checks each access on its first enabled cycle and each ack.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      if (ram_en) begin
        mon_en_cnt++;
        if (mon_first) begin
          mon_first = 1'b0;
          if (sb_q.size() == 0) begin
            chk("ram_en_unexpected", 64'(ram_en), 64'(0));
          end else begin
            e = sb_q[0];
            chk("ram_addr", 64'(ram_addr), 64'(e.addr));
            chk("ram_we", 64'(ram_we), 64'(e.we));
            chk("ram_wdata", ram_wdata, e.wdata);
            chk("owner_grant", 64'(owner), 64'(e.own));
          end
        end
      end
      if (ic_ack || dc_ack) begin
        ack_count++;
        if (sb_q.size() == 0) begin
          chk("ack_unexpected", 64'({ic_ack, dc_ack}), 64'(0));
        end else begin
          e = sb_q.pop_front();
          chk("ic_ack", 64'(ic_ack), 64'(e.own == OWNER_IC));
          chk("dc_ack", 64'(dc_ack), 64'(e.own == OWNER_DC));
          chk("owner_ack", 64'(owner), 64'(e.own));
          chk("data", (e.own == OWNER_DC) ? dc_data : ic_data, e.data);
          chk("err", 64'(err), 64'(e.err));
          chk("en_cycles", 64'(mon_en_cnt), 64'(e.en_cycles));
          $display("ack owner=%0d data=%h err=%0d en_cycles=%0d", owner,
                   (e.own == OWNER_DC) ? dc_data : ic_data, err, mon_en_cnt);
        end
        mon_en_cnt = 0;
        mon_first  = 1'b1;
      end
    end
  end

  // Overall time guard.
  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  localparam logic [LW-1:0] R1 = 64'hDEADBEEF_CAFEF00D;
  localparam logic [LW-1:0] R2 = 64'h0123_4567_89AB_CDEF;
  localparam logic [LW-1:0] R4 = 64'hA5A5_5A5A_0F0F_F0F0;
  localparam logic [LW-1:0] R5 = 64'h1111_2222_3333_4444;
  localparam logic [LW-1:0] R6 = 64'h6666_7777_8888_9999;
  localparam logic [LW-1:0] WD = 64'h5555_5555_5555_5555;

  // Directed stimulus.
  initial begin
    int base;
    reset = 1'b0; ic_req = 1'b0; dc_req = 1'b0; dc_we = 1'b0;
    ic_addr = '0; dc_addr = '0; dc_wdata = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ram_en", 64'(ram_en), 64'(0));
    chk("rst_acks", 64'({ic_ack, dc_ack, err}), 64'(0));
    chk("rst_ram_addr", 64'(ram_addr), 64'(0));
    chk("rst_ram_wdata", ram_wdata, 64'(0));
    chk("rst_owner", 64'({owner, ram_we}), 64'(0));
    chk("rst_data", ic_data | dc_data, 64'(0));
    reset = 1'b1;
    @(negedge clk); #1;

    // 1: single icache read
    base = ack_count;
    done_at = 3; rdata_val = R1;
    push(OWNER_IC, 32'h100, 1'b0, '0, R1, 1'b0, 3);
    ic_addr = 32'h100; ic_req = 1'b1;
    wait_acks(base + 1, 40);
    ic_req = 1'b0;
    @(negedge clk); #1;

    // 2: simultaneous requests right after reset, then continuous alternation
    reset = 1'b0;
    @(negedge clk); #1;
    reset = 1'b1;
    sb_q.delete(); mon_en_cnt = 0; mon_first = 1'b1;
    base = ack_count;
    done_at = 1; rdata_val = R2;
    ic_addr = 32'h300; dc_addr = 32'h200; dc_we = 1'b0; dc_wdata = WD;
    push(OWNER_IC, 32'h300, 1'b0, '0, R2, 1'b0, 1);
    push(OWNER_DC, 32'h200, 1'b0, WD, R2, 1'b0, 1);
    push(OWNER_IC, 32'h300, 1'b0, '0, R2, 1'b0, 1);
    push(OWNER_DC, 32'h200, 1'b0, WD, R2, 1'b0, 1);
    ic_req = 1'b1; dc_req = 1'b1;
    wait_acks(base + 4, 60);
    ic_req = 1'b0; dc_req = 1'b0;
    @(negedge clk); #1;

    // 3: dcache write
    base = ack_count;
    done_at = 2; rdata_val = 64'hFFFF_FFFF_FFFF_FFFF;
    dc_we = 1'b1; dc_addr = 32'h40; dc_wdata = 64'h11223344_55667788;
    push(OWNER_DC, 32'h40, 1'b1, 64'h11223344_55667788, '0, 1'b0, 2);
    dc_req = 1'b1;
    wait_acks(base + 1, 40);
    dc_req = 1'b0; dc_we = 1'b0; dc_wdata = WD;
    @(negedge clk); #1;

    // 4a: RAM never completes -> watchdog abort after 16 enabled cycles
    base = ack_count;
    done_at = 0; rdata_val = R4;
    dc_addr = 32'h80;
    push(OWNER_DC, 32'h80, 1'b0, WD, '0, 1'b1, 16);
    dc_req = 1'b1;
    wait_acks(base + 1, 60);
    dc_req = 1'b0;
    @(negedge clk); #1;

    // 4b: completion on the last watchdog cycle wins over the abort
    base = ack_count;
    done_at = 16;
    push(OWNER_DC, 32'h80, 1'b0, WD, R4, 1'b0, 16);
    dc_req = 1'b1;
    wait_acks(base + 1, 60);
    dc_req = 1'b0;
    @(negedge clk); #1;

    // 5: reset in the middle of an access, requests held across it
    base = ack_count;
    done_at = 0; dc_addr = 32'h90;
    push(OWNER_DC, 32'h90, 1'b0, WD, '0, 1'b0, 0);
    dc_req = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    ic_addr = 32'h500; ic_req = 1'b1;
    reset = 1'b0;
    @(negedge clk); #1;
    chk("midrst_ram_en", 64'(ram_en), 64'(0));
    chk("midrst_acks", 64'({ic_ack, dc_ack, err}), 64'(0));
    chk("midrst_owner", 64'(owner), 64'(0));
    chk("midrst_ack_count", 64'(ack_count), 64'(base));
    sb_q.delete(); mon_en_cnt = 0; mon_first = 1'b1;
    done_at = 2; rdata_val = R5;
    push(OWNER_IC, 32'h500, 1'b0, '0, R5, 1'b0, 2);
    push(OWNER_DC, 32'h90, 1'b0, WD, R5, 1'b0, 2);
    reset = 1'b1;
    wait_acks(base + 2, 60);
    ic_req = 1'b0; dc_req = 1'b0;
    @(negedge clk); #1;

    // 6: stray ram_done in IDLE and RESP
    base = ack_count;
    stray = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    chk("stray_idle_en", 64'(ram_en), 64'(0));
    chk("stray_idle_acks", 64'(ack_count), 64'(base));
    done_at = 1; rdata_val = R6; ic_addr = 32'h600;
    push(OWNER_IC, 32'h600, 1'b0, '0, R6, 1'b0, 1);
    ic_req = 1'b1;
    wait_acks(base + 1, 40);
    ic_req = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    chk("stray_resp_acks", 64'(ack_count), 64'(base + 1));
    chk("stray_resp_en", 64'(ram_en), 64'(0));
    stray = 1'b0;
    chk("sb_empty", 64'(sb_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
